// File: rtl/fp_sub_seq_if.sv
// Request/result bundle between a controller and the sequential FP subtractor.
// Latency: none, wires only.
// Backpressure: the subtractor holds busy high while an operation is in flight; start is ignored then.
interface fp_sub_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        ovf;

    modport master (
        output start, a, b,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single subtractor (a - b), truncating, denormals flushed; one-bit shifts per cycle.
// Latency: done rises after accept edge + 3 + align shifts + norm shifts; specials after 2 edges.
// Backpressure: busy is high from accept until done; start while busy is dropped, start with done is accepted.
module fp_sub_seq #(
    parameter int ALIGN_CAP = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_sub_seq_if.slave  bus
);

    localparam int CW = $clog2(ALIGN_CAP + 1);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, SUB, NORM, PACK} state_t;

    state_t          state, state_nxt;

    logic [31:0]     a_r, b_r;
    logic            sign_r;        // sign of the larger-magnitude operand
    logic            zsign_r;       // sign used when the difference is exactly zero
    logic            eff_sub_r;
    logic [8:0]      exp_r;         // one spare bit so overflow to 255 is visible
    logic [23:0]     mx_r;
    logic [26:0]     ym_r;          // mantissa, guard, round, sticky
    logic [27:0]     mant_r;        // carry, mantissa, guard, round, sticky
    logic [CW-1:0]   cnt_r;
    logic            spec_r;
    logic [31:0]     spec_val_r;
    logic [31:0]     result_r;
    logic            ovf_r;
    logic            done_r;

    // unpack decode signals
    logic            sa, sb, sx;
    logic [7:0]      ea, eb, ex, ey, diff;
    logic [22:0]     fa, fb;
    logic [23:0]     ma, mb, mx_c, my_c;
    logic            a_nan, b_nan, a_inf, b_inf, swap;
    logic            spec_c;
    logic [31:0]     spec_val_c;
    logic [CW-1:0]   d_c;
    logic [27:0]     sum_c;

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.ovf    = ovf_r;

    // Operand decode: flip b, flush denormals, order by magnitude, detect specials.
    always_comb begin
        sa    = a_r[31];
        sb    = ~b_r[31];
        ea    = a_r[30:23];
        eb    = b_r[30:23];
        fa    = (ea == 8'd0) ? 23'd0 : a_r[22:0];
        fb    = (eb == 8'd0) ? 23'd0 : b_r[22:0];
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, fa};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, fb};
        a_nan = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
        swap  = {eb, fb} > {ea, fa};
        sx    = swap ? sb : sa;
        ex    = swap ? eb : ea;
        ey    = swap ? ea : eb;
        mx_c  = swap ? mb : ma;
        my_c  = swap ? ma : mb;
        diff  = ex - ey;
        d_c   = ({1'b0, diff} >= 9'(ALIGN_CAP)) ? CW'(ALIGN_CAP) : diff[CW-1:0];
        spec_c = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            spec_val_c = 32'h7FC0_0000;
        else if (a_inf)
            spec_val_c = {sa, 8'hFF, 23'd0};
        else
            spec_val_c = {sb, 8'hFF, 23'd0};
    end

    // Single mantissa add/subtract; X is never smaller than Y so no borrow out.
    always_comb begin
        sum_c = eff_sub_r ? ({1'b0, mx_r, 3'b000} - {1'b0, ym_r})
                          : ({1'b0, mx_r, 3'b000} + {1'b0, ym_r});
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start) state_nxt = UNPACK;
            UNPACK: begin
                if (spec_c)               state_nxt = PACK;
                else if (d_c != '0)       state_nxt = ALIGN;
                else                      state_nxt = SUB;
            end
            ALIGN:  if (cnt_r == CW'(1)) state_nxt = SUB;
            SUB: begin
                if (sum_c == 28'd0)                 state_nxt = PACK;
                else if (sum_c[27] || !sum_c[26])   state_nxt = NORM;
                else                                state_nxt = PACK;
            end
            NORM: begin
                // carry fixes in one step; a left shift ends on a leading one or exponent underflow
                if (mant_r[27] || exp_r == 9'd1 || mant_r[25]) state_nxt = PACK;
            end
            PACK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, alignment, subtraction, normalization and result packing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            sign_r     <= 1'b0;
            zsign_r    <= 1'b0;
            eff_sub_r  <= 1'b0;
            exp_r      <= '0;
            mx_r       <= '0;
            ym_r       <= '0;
            mant_r     <= '0;
            cnt_r      <= '0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
            result_r   <= '0;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                    end
                end
                UNPACK: begin
                    sign_r     <= sx;
                    zsign_r    <= sa & sb;
                    eff_sub_r  <= sa ^ sb;
                    exp_r      <= {1'b0, ex};
                    mx_r       <= mx_c;
                    ym_r       <= {my_c, 3'b000};
                    cnt_r      <= d_c;
                    spec_r     <= spec_c;
                    spec_val_r <= spec_val_c;
                end
                ALIGN: begin
                    ym_r  <= {1'b0, ym_r[26:2], ym_r[1] | ym_r[0]};
                    cnt_r <= cnt_r - CW'(1);
                end
                SUB: begin
                    mant_r <= sum_c;
                end
                NORM: begin
                    if (mant_r[27]) begin
                        mant_r <= {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                        exp_r  <= exp_r + 9'd1;
                    end else begin
                        mant_r <= {mant_r[26:0], 1'b0};
                        exp_r  <= exp_r - 9'd1;
                    end
                end
                PACK: begin
                    done_r <= 1'b1;
                    ovf_r  <= 1'b0;
                    if (spec_r)
                        result_r <= spec_val_r;
                    else if (mant_r == 28'd0)
                        result_r <= {zsign_r, 31'd0};
                    else if (exp_r == 9'd0)
                        result_r <= {sign_r, 31'd0};
                    else if (exp_r >= 9'd255) begin
                        result_r <= {sign_r, 8'hFF, 23'd0};
                        ovf_r    <= 1'b1;
                    end else
                        result_r <= {sign_r, exp_r[7:0], mant_r[25:3]};
                end
                default: ;
            endcase
        end
    end

endmodule
